// File: rtl/seq_gen_pkg.sv
// Shared encodings for the major-state sequencer: state codes, run modes and
// the readout code for an execute state.
package seq_gen_pkg;

  localparam int STATE_W   = 4;
  localparam int EXEC_BASE = 5;

  // ST_EXEC stands for "some execute state"; the index lives in its own register.
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE     = 4'd0,
    ST_FETCH    = 4'd1,
    ST_AUTOINC1 = 4'd2,
    ST_AUTOINC2 = 4'd3,
    ST_INDIRECT = 4'd4,
    ST_EXEC     = 4'd5
  } state_t;

  typedef enum logic [1:0] {
    MODE_NONE  = 2'd0,
    MODE_CONT  = 2'd1,
    MODE_INSTR = 2'd2,
    MODE_CYCLE = 2'd3
  } mode_t;

  // Readout code of EXEC k; saturates at the top code when N_EXEC is large.
  function automatic logic [STATE_W-1:0] exec_code(input int unsigned k);
    int unsigned c;
    c = EXEC_BASE + k;
    return (c > 15) ? 4'hF : STATE_W'(c);
  endfunction

endpackage

// File: rtl/seq_edge_det.sv
// Rising-edge detector: one flop remembers the previous level, rise is high
// for the clock in which the level is 1 and was 0 on the previous edge.
module seq_edge_det (
  input  logic ck,
  input  logic clear,
  input  logic level,
  output logic rise
);

  logic prev_q;

  always_ff @(posedge ck or posedge clear) begin
    if (clear) prev_q <= 1'b0;
    else       prev_q <= level;
  end

  assign rise = level & ~prev_q;

endmodule

// File: rtl/sequencer_gen.sv
// Major-state sequencer: FETCH, optional AUTOINC1/AUTOINC2/INDIRECT and a
// per-instruction number of EXEC states, each TICKS clocks with STB/CK pulses.
module sequencer_gen
  import seq_gen_pkg::*;
#(
  parameter int N_EXEC = 6,
  parameter int TICKS  = 2,
  parameter int LEN_W  = $clog2(N_EXEC + 1)
) (
  input  logic              CK,
  input  logic              CLEAR,
  input  logic              RUN,
  input  logic              HALT,
  input  logic              STEPI,
  input  logic              STEPC,
  input  logic              NOAUTO,
  input  logic              NOIND,
  input  logic [LEN_W-1:0]  EXEC_LEN,
  output logic              CK_FETCH,
  output logic              CK_AUTOINC1,
  output logic              CK_AUTOINC2,
  output logic              CK_INDIRECT,
  output logic              STB_FETCH,
  output logic              STB_AUTOINC1,
  output logic              STB_AUTOINC2,
  output logic              STB_INDIRECT,
  output logic [N_EXEC-1:0] CK_EXEC,
  output logic [N_EXEC-1:0] STB_EXEC,
  output logic [3:0]        STATE,
  output logic              BUSY,
  output logic              INSTR_DONE
);

  localparam int TICK_W = $clog2(TICKS);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS - 1);
  localparam logic [LEN_W-1:0]  LEN_MAX   = LEN_W'(N_EXEC);
  localparam logic [LEN_W-1:0]  LEN_ONE   = LEN_W'(1);

  state_t            state_q, state_d;
  mode_t             mode_q, mode_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic              hold_q, hold_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  idx_q, idx_d;

  logic run_go;
  logic stepi_rise;
  logic stepc_rise;
  logic last_exec;
  logic [LEN_W-1:0] len_in;

  seq_edge_det u_stepi_det (
    .ck    (CK),
    .clear (CLEAR),
    .level (STEPI),
    .rise  (stepi_rise)
  );

  seq_edge_det u_stepc_det (
    .ck    (CK),
    .clear (CLEAR),
    .level (STEPC),
    .rise  (stepc_rise)
  );

  assign run_go    = RUN & HALT;
  assign last_exec = (state_q == ST_EXEC) && (idx_q == len_q - LEN_ONE);

  always_comb begin
    if (EXEC_LEN == '0)          len_in = LEN_ONE;
    else if (EXEC_LEN > LEN_MAX) len_in = LEN_MAX;
    else                         len_in = EXEC_LEN;
  end

  always_ff @(posedge CK or posedge CLEAR) begin
    if (CLEAR) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_NONE;
      tick_q  <= '0;
      hold_q  <= 1'b0;
      len_q   <= LEN_ONE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      tick_q  <= tick_d;
      hold_q  <= hold_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_t nxt;
    logic   end_instr;
    state_d   = state_q;
    mode_d    = mode_q;
    tick_d    = tick_q;
    hold_d    = hold_q;
    len_d     = len_q;
    idx_d     = idx_q;
    nxt       = ST_IDLE;
    end_instr = 1'b0;

    if (state_q == ST_IDLE) begin
      tick_d = '0;
      hold_d = 1'b0;
      if (run_go) begin
        state_d = ST_FETCH;
        mode_d  = MODE_CONT;
      end else if (stepi_rise) begin
        state_d = ST_FETCH;
        mode_d  = MODE_INSTR;
      end else if (stepc_rise) begin
        state_d = ST_FETCH;
        mode_d  = MODE_CYCLE;
      end
    end else if (hold_q) begin
      // Cycle-step hold: the held state starts on the edge that sees the request.
      if (run_go) begin
        mode_d = MODE_CONT;
        hold_d = 1'b0;
      end else if (stepi_rise) begin
        mode_d = MODE_INSTR;
        hold_d = 1'b0;
      end else if (stepc_rise) begin
        hold_d = 1'b0;
      end
    end else if (tick_q != TICK_LAST) begin
      tick_d = tick_q + 1'b1;
    end else begin
      tick_d = '0;
      case (state_q)
        ST_FETCH: begin
          len_d = len_in;
          idx_d = '0;
          if (NOIND)       nxt = ST_EXEC;
          else if (NOAUTO) nxt = ST_INDIRECT;
          else             nxt = ST_AUTOINC1;
        end
        ST_AUTOINC1: nxt = ST_AUTOINC2;
        ST_AUTOINC2: nxt = ST_INDIRECT;
        ST_INDIRECT: begin
          nxt   = ST_EXEC;
          idx_d = '0;
        end
        ST_EXEC: begin
          if (last_exec) begin
            end_instr = 1'b1;
          end else begin
            nxt   = ST_EXEC;
            idx_d = idx_q + LEN_ONE;
          end
        end
        default: nxt = ST_IDLE;
      endcase

      if (end_instr) begin
        if (mode_q == MODE_CONT && run_go) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_IDLE;
          mode_d  = MODE_NONE;
        end
      end else begin
        state_d = nxt;
        if (mode_q == MODE_CYCLE) hold_d = 1'b1;
      end
    end
  end

  always_comb begin
    logic stb_now;
    logic ck_now;
    stb_now      = !hold_q && (tick_q == '0);
    ck_now       = !hold_q && (tick_q == TICK_LAST);
    STB_FETCH    = stb_now && (state_q == ST_FETCH);
    STB_AUTOINC1 = stb_now && (state_q == ST_AUTOINC1);
    STB_AUTOINC2 = stb_now && (state_q == ST_AUTOINC2);
    STB_INDIRECT = stb_now && (state_q == ST_INDIRECT);
    CK_FETCH     = ck_now && (state_q == ST_FETCH);
    CK_AUTOINC1  = ck_now && (state_q == ST_AUTOINC1);
    CK_AUTOINC2  = ck_now && (state_q == ST_AUTOINC2);
    CK_INDIRECT  = ck_now && (state_q == ST_INDIRECT);
    STB_EXEC     = '0;
    CK_EXEC      = '0;
    for (int k = 0; k < N_EXEC; k++) begin
      STB_EXEC[k] = stb_now && (state_q == ST_EXEC) && (idx_q == LEN_W'(k));
      CK_EXEC[k]  = ck_now && (state_q == ST_EXEC) && (idx_q == LEN_W'(k));
    end
    BUSY       = (state_q != ST_IDLE);
    INSTR_DONE = ck_now && last_exec;
    STATE      = (state_q == ST_EXEC) ? exec_code(32'(idx_q)) : state_q;
  end

endmodule
